lcd_refresh_scheduler: RTL and testbench
========================================

// Module: lcd_refresh_scheduler
// PURPOSE
//  Sequences the LCD SPI transmit FIFO. Streams a page-organised framebuffer (PAGES x COLS bytes) to the LCD
//  as {I/D,payload} words: per page, 3 command words then COLS data words. Arbitrates FIFO write access
//  between this refresh engine and a CPU pass-through port; CPU words enter only at page boundaries.
//  Sits between the bus slave logic / framebuffer RAM and the 16-deep 9-bit SPI FIFO (wr/full handshake).
// PARAMETERS
//  PAGES        8         framebuffer pages (rows of 8 pixels), >=1
//  COLS         128       columns per page, >=1
//  COL_OFFSET   0         added to column address sent in the column commands (0..255-COLS)
//  FB_AW        10        framebuffer address width, >= clog2(PAGES*COLS)
//  REFRESH_DIV  1000000   clk cycles between auto-refresh triggers (used only with LCD_SCHED_AUTOREFRESH_EN)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  enable     in   1      scheduler enable (status bit lcd_enable)
//  start      in   1      1-cycle pulse: request one full-frame refresh
//  busy       out  1      high from accepted start until done / abort
//  done       out  1      1-cycle pulse after last data word of last page written to FIFO
//  cpu_wr     in   1      CPU word request (level, held until cpu_ack)
//  cpu_din    in   9      CPU word {I/D, payload}
//  cpu_ack    out  1      1-cycle pulse: cpu_din written to FIFO this cycle
//  fb_rd      out  1      framebuffer read strobe
//  fb_addr    out  FB_AW  framebuffer address = page*COLS + col
//  fb_data    in   8      framebuffer read data, valid exactly 1 cycle after fb_rd
//  fifo_wr    out  1      FIFO write strobe; never high while fifo_full
//  fifo_din   out  9      FIFO write data {I/D, payload}
//  fifo_full  in   1      FIFO full
// BEHAVIOUR
//  Reset: state IDLE; busy, done, cpu_ack, fb_rd, fifo_wr = 0; fb_addr, fifo_din = 0; page/col counters = 0; pending start cleared.
//  States: IDLE, CPU, CMD_PAGE, CMD_CLO, CMD_CHI, DATA, PAGE_END.
//   IDLE: cpu_wr & enable -> CPU; else pending start & enable -> CMD_PAGE, busy=1, page=0.
//   CPU: when !fifo_full: fifo_wr=1, fifo_din=cpu_din, cpu_ack=1; -> PAGE_END if busy else IDLE.
//   CMD_PAGE: write {0, 8'hB0|page[3:0]}; CMD_CLO: {0, 8'h00|ca[3:0]}; CMD_CHI: {0, 8'h10|ca[7:4]}, ca=COL_OFFSET.
//    Each command state advances only in the cycle its word is written (fifo_full=0).
//   DATA: issue fb_rd for col 0..COLS-1; each returned byte written as {1, fb_data}. fb_data captured into a
//    1-entry hold register; next fb_rd issued only when hold register is empty or being drained this cycle.
//    No byte lost or duplicated under any fifo_full pattern. After col COLS-1 written -> PAGE_END.
//   PAGE_END: page==PAGES-1 -> done=1, busy=0, IDLE. Else page++, col=0; cpu_wr -> CPU (one word, then back);
//    else !enable -> abort: busy=0, no done, IDLE; else -> CMD_PAGE.
//  Priority: CPU wins at IDLE and PAGE_END only; never within a page (column auto-increment must not break).
//  start while busy: latched as 1 pending request (further starts merged), serviced after done.
//  enable low in IDLE: nothing issued; pending start retained. enable low mid-page: page completes first.
//  Throughput: 1 word/cycle in DATA when FIFO not full (pipelined read); fb read latency fixed at 1 cycle.
//  Counters: page width clog2(PAGES)+1, col width clog2(COLS)+1; no wrap beyond terminal values.
//  rst mid-frame: immediate return to reset state; any in-flight fb_data discarded.
// CONFIGURATION
//  `LCD_SCHED_AUTOREFRESH_EN defined: free-running counter 0..REFRESH_DIV-1 (runs only while enable);
//   terminal count sets pending start (merged with start pulse). Undefined: refresh only via start; no counter logic.
// STRUCTURE
//  Shared header lcd_sched_defs.vh: state encodings (3-bit localparams), LCD opcodes
//   CMD_SET_PAGE=8'hB0, CMD_COL_LO=8'h00, CMD_COL_HI=8'h10, ID_CMD=1'b0, ID_DATA=1'b1.
//  One sub-module: lcd_refresh_timer (REFRESH_DIV counter, tick output), instantiated only under the macro.
// TESTING
//  1 PAGES=2,COLS=4, fb=00..07, fifo_full=0, start -> FIFO gets B0,00,10,00..03 (ID=1 on data), B1,00,10,04..07; done once.
//  2 As 1, fifo_full toggled pseudo-randomly 50% -> identical word sequence, fifo_wr never high while full.
//  3 cpu_wr=1,cpu_din=9'h0AF during page 0 data -> 0AF written after page 0's last data word, before B1; one cpu_ack.
//  4 start pulsed twice while busy -> exactly two frames emitted back-to-back, two done pulses.
//  5 enable dropped mid page 0 -> page 0 completes, no B1, busy falls, no done; rst mid-DATA -> all outputs 0 next cycle.
//  6 macro on, REFRESH_DIV=100, enable=1 -> a frame starts every 100 cycles; macro off -> no activity without start.

Source files
------------

// File: rtl/lcd_refresh_scheduler_pkg.sv
// Shared state encoding and LCD command opcodes for the refresh scheduler.
package lcd_refresh_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU      = 3'd1,
        S_CMD_PAGE = 3'd2,
        S_CMD_CLO  = 3'd3,
        S_CMD_CHI  = 3'd4,
        S_DATA     = 3'd5,
        S_PAGE_END = 3'd6
    } state_e;

    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;
    localparam logic       ID_CMD       = 1'b0;
    localparam logic       ID_DATA      = 1'b1;

    function automatic logic [8:0] cmd_word(input logic [7:0] op, input logic [3:0] arg);
        return {ID_CMD, op | {4'h0, arg}};
    endfunction

endpackage

// File: rtl/lcd_refresh_scheduler_if.sv
// CPU pass-through, framebuffer read and SPI FIFO write signals of the refresh scheduler.
interface lcd_refresh_scheduler_if #(
    parameter int unsigned FB_AW = 10
);
    logic             cpu_wr;
    logic [8:0]       cpu_din;
    logic             cpu_ack;
    logic             fb_rd;
    logic [FB_AW-1:0] fb_addr;
    logic [7:0]       fb_data;
    logic             fifo_wr;
    logic [8:0]       fifo_din;
    logic             fifo_full;

    modport master (
        input  cpu_wr, cpu_din, fb_data, fifo_full,
        output cpu_ack, fb_rd, fb_addr, fifo_wr, fifo_din
    );

    modport slave (
        output cpu_wr, cpu_din, fb_data, fifo_full,
        input  cpu_ack, fb_rd, fb_addr, fifo_wr, fifo_din
    );
endinterface

// File: rtl/lcd_refresh_timer.sv
// Free-running auto-refresh divider: tick pulses once every REFRESH_DIV enabled cycles.
module lcd_refresh_timer
    import lcd_refresh_scheduler_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [W-1:0] TERM = W'(REFRESH_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = en && (cnt_q == TERM);
endmodule

// File: rtl/lcd_refresh_scheduler.sv
// Streams a PAGES x COLS framebuffer into the LCD SPI FIFO and arbitrates CPU words at page boundaries.
// Optional auto-refresh divider enabled by defining LCD_SCHED_AUTOREFRESH_EN.
module lcd_refresh_scheduler
    import lcd_refresh_scheduler_pkg::*;
#(
    parameter int unsigned PAGES       = 8,
    parameter int unsigned COLS        = 128,
    parameter int unsigned COL_OFFSET  = 0,
    parameter int unsigned FB_AW       = 10,
    parameter int unsigned REFRESH_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic start,
    output logic busy,
    output logic done,
    lcd_refresh_scheduler_if.master bus
);
    localparam int unsigned PW = $clog2(PAGES) + 1;
    localparam int unsigned CW = $clog2(COLS) + 1;
    localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
    localparam logic [CW-1:0] NCOLS     = CW'(COLS);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [7:0]    CA        = 8'(COL_OFFSET);

    state_e        state_q, state_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          busy_q, busy_d;
    logic          pend_q, pend_d;
    logic          cpu_sv_q, cpu_sv_d;
    logic          rd_pend_q, rd_pend_d;
    logic          hold_v_q, hold_v_d;
    logic [7:0]    hold_q, hold_d;

    logic          tick;
    logic          take;
    logic          word_v;
    logic [8:0]    word;
    logic          data_wr;
    logic          fb_rd_c;
    logic          done_c;
    logic          ack_c;
    logic [3:0]    page4;

`ifdef LCD_SCHED_AUTOREFRESH_EN
    lcd_refresh_timer #(.REFRESH_DIV(REFRESH_DIV)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (enable),
        .tick (tick)
    );
`else
    assign tick = 1'b0;
`endif

    assign page4 = 4'(page_q);

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        col_d     = col_q;
        wcnt_d    = wcnt_q;
        busy_d    = busy_q;
        cpu_sv_d  = cpu_sv_q;
        rd_pend_d = 1'b0;
        hold_v_d  = hold_v_q;
        hold_d    = hold_q;
        take      = 1'b0;
        word_v    = 1'b0;
        word      = '0;
        data_wr   = 1'b0;
        fb_rd_c   = 1'b0;
        done_c    = 1'b0;
        ack_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cpu_wr && enable) begin
                    state_d = S_CPU;
                end else if (pend_q && enable) begin
                    state_d = S_CMD_PAGE;
                    busy_d  = 1'b1;
                    take    = 1'b1;
                    page_d  = '0;
                    col_d   = '0;
                    wcnt_d  = '0;
                end
            end
            S_CPU: begin
                word_v = 1'b1;
                word   = bus.cpu_din;
                if (!bus.fifo_full) begin
                    ack_c   = 1'b1;
                    state_d = busy_q ? S_PAGE_END : S_IDLE;
                end
            end
            S_CMD_PAGE: begin
                word_v = 1'b1;
                word   = cmd_word(CMD_SET_PAGE, page4);
                if (!bus.fifo_full) state_d = S_CMD_CLO;
            end
            S_CMD_CLO: begin
                word_v = 1'b1;
                word   = cmd_word(CMD_COL_LO, CA[3:0]);
                if (!bus.fifo_full) state_d = S_CMD_CHI;
            end
            S_CMD_CHI: begin
                word_v = 1'b1;
                word   = cmd_word(CMD_COL_HI, CA[7:4]);
                if (!bus.fifo_full) state_d = S_DATA;
            end
            S_DATA: begin
                // At most one byte is ever buffered: a read is issued only if nothing remains held after this cycle.
                word_v   = hold_v_q || rd_pend_q;
                word     = {ID_DATA, hold_v_q ? hold_q : bus.fb_data};
                data_wr  = word_v && !bus.fifo_full;
                hold_v_d = word_v && !data_wr;
                if (rd_pend_q && !hold_v_q && !data_wr) hold_d = bus.fb_data;
                if (!hold_v_d && (col_q != NCOLS)) begin
                    fb_rd_c   = 1'b1;
                    rd_pend_d = 1'b1;
                    col_d     = col_q + 1'b1;
                end
                if (data_wr) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_COL) state_d = S_PAGE_END;
                end
            end
            S_PAGE_END: begin
                // Page advance is deferred to the CMD_PAGE transition so a CPU detour re-enters here unchanged.
                if (page_q == LAST_PAGE) begin
                    done_c   = 1'b1;
                    busy_d   = 1'b0;
                    cpu_sv_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (bus.cpu_wr && !cpu_sv_q) begin
                    cpu_sv_d = 1'b1;
                    state_d  = S_CPU;
                end else if (!enable) begin
                    busy_d   = 1'b0;
                    cpu_sv_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    page_d   = page_q + 1'b1;
                    col_d    = '0;
                    wcnt_d   = '0;
                    cpu_sv_d = 1'b0;
                    state_d  = S_CMD_PAGE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_d = (pend_q && !take) || start || tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            page_q    <= '0;
            col_q     <= '0;
            wcnt_q    <= '0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            cpu_sv_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            hold_v_q  <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            col_q     <= col_d;
            wcnt_q    <= wcnt_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            cpu_sv_q  <= cpu_sv_d;
            rd_pend_q <= rd_pend_d;
            hold_v_q  <= hold_v_d;
            hold_q    <= hold_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_c;
    assign bus.cpu_ack  = ack_c;
    assign bus.fb_rd    = fb_rd_c;
    assign bus.fb_addr  = FB_AW'(page_q) * FB_AW'(COLS) + FB_AW'(col_q);
    assign bus.fifo_wr  = word_v && !bus.fifo_full;
    assign bus.fifo_din = word;
endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Directed bench for lcd_refresh_scheduler with PAGES=2, COLS=4 and framebuffer byte = address.
module tb_lcd_refresh_scheduler;
    localparam int unsigned PAGES = 2;
    localparam int unsigned COLS  = 4;
    localparam int unsigned FB_AW = 3;

    logic clk = 1'b0;
    logic rst, enable, start;
    logic busy, done;

    lcd_refresh_scheduler_if #(.FB_AW(FB_AW)) bus ();

    lcd_refresh_scheduler #(
        .PAGES(PAGES), .COLS(COLS), .COL_OFFSET(0), .FB_AW(FB_AW), .REFRESH_DIV(100)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // framebuffer model: one-cycle read latency, junk when not reading
    always @(posedge clk) bus.fb_data <= bus.fb_rd ? 8'(bus.fb_addr) : 8'hEE;

    logic [8:0] wlog[$];
    logic [8:0] exp_q[$];
    int viol, done_cnt, ack_cnt;
    bit data_seen, rand_full, cpu_arm;
    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        if (bus.fifo_wr) begin
            wlog.push_back(bus.fifo_din);
            if (bus.fifo_full) viol++;
            if (bus.fifo_din[8]) data_seen = 1'b1;
        end
        if (done) done_cnt++;
        if (bus.cpu_ack) ack_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.fifo_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
        if (cpu_arm && data_seen && ack_cnt == 0) begin
            bus.cpu_wr  = 1'b1;
            bus.cpu_din = 9'h0AF;
        end else begin
            bus.cpu_wr = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic clear_mon();
        wlog.delete();
        viol = 0; done_cnt = 0; ack_cnt = 0; data_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; enable = 1'b0;
        rand_full = 1'b0; cpu_arm = 1'b0;
        run(2);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic push_page(input int p);
        exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h010);
        for (int c = 0; c < int'(COLS); c++) exp_q.push_back({1'b1, 8'(p * int'(COLS) + c)});
    endtask

    task automatic compare_log(input string tag);
        int n;
        chk({tag, "_len"}, wlog.size(), exp_q.size());
        n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", tag, i), int'(wlog[i]), int'(exp_q[i]));
    endtask

    task automatic wait_data(input string tag);
        for (int i = 0; i < 60 && !data_seen; i++) tick_cycle();
        chk({tag, "_data_seen"}, int'(data_seen), 1);
    endtask

    typedef struct {
        string name;
        bit    rnd_full;
        bit    cpu;
        int    extra_starts;
        int    frames;
        int    exp_done;
        int    exp_ack;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{"plain", 1'b0, 1'b0, 0, 1, 1, 0};
        tbl[1] = '{"full50", 1'b1, 1'b0, 0, 1, 1, 0};
        tbl[2] = '{"cpu", 1'b0, 1'b1, 0, 1, 1, 1};
        tbl[3] = '{"dblstart", 1'b0, 1'b0, 2, 2, 2, 0};

        rst = 1'b1; enable = 1'b0; start = 1'b0;
        bus.cpu_wr = 1'b0; bus.cpu_din = '0; bus.fifo_full = 1'b0;
        rand_full = 1'b0; cpu_arm = 1'b0;

        do_reset();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fifo_wr", int'(bus.fifo_wr), 0);
        chk("rst_fb_rd", int'(bus.fb_rd), 0);
        chk("rst_fb_addr", int'(bus.fb_addr), 0);
        chk("rst_fifo_din", int'(bus.fifo_din), 0);
        chk("rst_cpu_ack", int'(bus.cpu_ack), 0);

        for (int k = 0; k < 4; k++) begin
            do_reset();
            enable = 1'b1;
            rand_full = tbl[k].rnd_full;
            cpu_arm = tbl[k].cpu;
            start = 1'b1;
            run(5);
            for (int e = 0; e < tbl[k].extra_starts; e++) begin
                start = 1'b1;
                run(3);
            end
            run(400);
            exp_q.delete();
            for (int f = 0; f < tbl[k].frames; f++) begin
                push_page(0);
                if (tbl[k].cpu) exp_q.push_back(9'h0AF);
                push_page(1);
            end
            compare_log(tbl[k].name);
            chk({tbl[k].name, "_done"}, done_cnt, tbl[k].exp_done);
            chk({tbl[k].name, "_ack"}, ack_cnt, tbl[k].exp_ack);
            chk({tbl[k].name, "_wr_while_full"}, viol, 0);
            chk({tbl[k].name, "_busy_end"}, int'(busy), 0);
        end

        // enable dropped during page 0 data: page 0 finishes, frame aborts without done
        do_reset();
        enable = 1'b1;
        start = 1'b1;
        wait_data("endrop");
        enable = 1'b0;
        run(100);
        exp_q.delete();
        push_page(0);
        compare_log("endrop");
        chk("endrop_done", done_cnt, 0);
        chk("endrop_busy", int'(busy), 0);

        // start while disabled stays pending until enable returns
        do_reset();
        start = 1'b1;
        run(30);
        chk("pend_idle_len", wlog.size(), 0);
        chk("pend_idle_busy", int'(busy), 0);
        enable = 1'b1;
        run(60);
        exp_q.delete();
        push_page(0);
        push_page(1);
        compare_log("pend");
        chk("pend_done", done_cnt, 1);

        // no refresh activity without a start request
        do_reset();
        enable = 1'b1;
        run(150);
`ifdef LCD_SCHED_AUTOREFRESH_EN
        chk("autorefresh_started", int'(done_cnt > 0), 1);
`else
        chk("noauto_len", wlog.size(), 0);
`endif

        // reset in the middle of page 0 data
        do_reset();
        enable = 1'b1;
        start = 1'b1;
        wait_data("midrst");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cpu_ack", int'(bus.cpu_ack), 0);
        chk("midrst_fb_rd", int'(bus.fb_rd), 0);
        chk("midrst_fifo_wr", int'(bus.fifo_wr), 0);
        chk("midrst_fb_addr", int'(bus.fb_addr), 0);
        chk("midrst_fifo_din", int'(bus.fifo_din), 0);
        #1;
        rst = 1'b0;
        clear_mon();
        enable = 1'b0;
        run(40);
        chk("midrst_quiet_len", wlog.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
